demux1to8_deser: RTL and testbench
==================================

# demux1to8_deser

Serial-to-parallel collector for the receiving end of the 8-to-1 mux serial path. Accepts one bit per valid cycle, steers it into slot `sel` of an 8-bit capture register, and presents the reassembled word with a one-cycle valid strobe. Drives the `sel` index the upstream mux uses, so slot k always lands in `out[k]`.

## Interface
- `N_SLOTS`, default 8: number of slots per frame; fixed at 8 in this revision.
- `SEL_W`, default 3: slot index width, equal to clog2(`N_SLOTS`).
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  frame start; begins a new frame at slot 0.
- `in_valid`  input  1  `in_bit` is valid this cycle.
- `in_bit`  input  1  serial data bit for the current slot.
- `sel`  output  `SEL_W`  current slot index; drives the upstream mux select.
- `busy`  output  1  high while a frame is being collected.
- `out`  output  8  last completed word; holds until the next frame completes.
- `out_valid`  output  1  one-cycle strobe when `out` updates.
- `abort`  output  1  one-cycle strobe when a partial frame is discarded.

## Operation
- States: IDLE and COLLECT.
- IDLE:
  - `busy`=0 and `sel`=0; `in_valid` is ignored.
  - `start`=1 → COLLECT with `sel`=0.
- COLLECT, `in_valid`=1: capture bit `sel` ← `in_bit`, then `sel` += 1.
- COLLECT, `in_valid`=0: stall; `sel` and the capture register hold.
- Frame completion, COLLECT with `sel`=7 and `in_valid`=1:
  - `out` ← assembled word, with this cycle's bit in `out[7]`.
  - `out_valid` pulses.
  - `sel` wraps to 0.
  - Next state is IDLE, or COLLECT if `start`=1 in the same cycle.
- `start`=1 in COLLECT, not at completion:
  - Abort the partial frame: `abort` pulses and `sel` resets to 0.
  - The capture register is not copied to `out`.
  - The `in_bit` of that cycle is discarded, even if `in_valid`=1.
  - State stays COLLECT.
- `start`=1 at completion: the frame completes normally with `out_valid`=1 and no `abort`. A new frame starts at `sel`=0.
- Bit order: slot k → `out[k]`, LSB first, matching mux convention `out = in[sel]`.
- `sel` is a registered output; no combinational path from inputs to any output.

## Timing
- Reset values (async on `rst`=1): `sel`=0, `busy`=0, `out`=8'h00, `out_valid`=0, `abort`=0, capture register 0, state IDLE.
- `busy` rises the cycle after `start` is sampled in IDLE.
- The first bit is accepted on the first `in_valid` cycle after entry to COLLECT. `in_valid` in the `start` cycle itself is ignored.
- Minimum frame: 1 start cycle + 8 valid cycles.
- `out` and `out_valid` are registered; both are visible the cycle after the 8th bit is accepted.
- `out_valid` and `abort` are never high together.
- `busy` is low in the `out_valid` cycle unless a back-to-back `start` occurred.
- Reset mid-frame: all state clears immediately and no `out_valid` is produced. `out` returns to 0.

## Structure
- Shared package `mux_pkg`:
  - `N_SLOTS` and `SEL_W` constants.
  - State enum {IDLE, COLLECT}.
  - Slot-index type.
- These are shared with the 8-to-1 mux and any future serializer.
- One natural sub-module: `slot_counter`, a modulo-`N_SLOTS` counter with enable, synchronous clear and wrap flag. It generates `sel` and the completion condition.
- The FSM and capture register live in the top level.

## Test plan
- Basic frame: reset, `start`, then 8 valid bits of 8'h55 LSB first (1,0,1,0,1,0,1,0) → `sel` steps 0..7. `out`=8'h55 with a single `out_valid` pulse; `busy` returns to 0.
- Stall: frame 8'hA3 with `in_valid` low for 3 cycles after slot 2 → `sel` holds at 3 during the stall. `out`=8'hA3 and `out_valid` arrives 3 cycles later than in the unstalled case.
- Abort: 4 bits of 8'hFF, then `start` → `abort` pulses, `sel`=0, and `out` keeps its previous 8'h55. A following full frame of 8'h0F yields `out`=8'h0F.
- Back-to-back: `start` asserted in the completion cycle of 8'h3C, then frame 8'hC3 → two `out_valid` pulses 9 cycles apart carrying 8'h3C then 8'hC3. No `abort` pulse; `busy` stays high across the boundary.
- Reset mid-frame: `rst` asserted after 5 bits → `sel`=0, `out`=8'h00 and `busy`=0 asynchronously, with no `out_valid`.
- Idle noise: `in_valid` toggling with no `start` → `sel` stays 0, with no `out_valid` and no `abort`.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and types for the 8-to-1 serial mux path.
// Used by the mux, this deserializer and any future serializer.
package mux_pkg;

  localparam int N_SLOTS = 8;
  localparam int SEL_W   = $clog2(N_SLOTS);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

  typedef logic [SEL_W-1:0] slot_t;

endpackage

// File: rtl/demux1to8_deser_slot_counter.sv
// slot_counter: modulo-N_SLOTS counter, enable + sync clear + wrap flag.
// Ports: clk, rst, en_i, clr_i in; cnt_o (registered), wrap_o out.
module slot_counter
  import mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             wrap_o
);

  slot_t cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == SEL_W'(N_SLOTS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux1to8_deser.sv
// demux1to8_deser: serial-to-parallel collector, slot sel -> out[sel].
// Ports: clk, rst, start, in_valid, in_bit in; sel, busy, out, out_valid, abort out.
module demux1to8_deser #(
  parameter int N_SLOTS = mux_pkg::N_SLOTS,
  parameter int SEL_W   = mux_pkg::SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic [N_SLOTS-1:0] out,
  output logic               out_valid,
  output logic               abort
);

  import mux_pkg::*;

  state_e state_q, state_d;

  logic [N_SLOTS-1:0] cap_q, cap_d;
  logic [N_SLOTS-1:0] out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               abort_q, abort_d;

  logic             cnt_en;
  logic             cnt_clr;
  logic             done;
  logic [SEL_W-1:0] sel_w;

  // Counter steps on every valid bit in COLLECT; a same-cycle clear
  // (abort) wins inside the counter, so the aborted bit never counts.
  assign cnt_en = (state_q == COLLECT) && in_valid;

  slot_counter u_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .cnt_o  (sel_w),
    .wrap_o (done)
  );

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    abort_d     = 1'b0;
    cnt_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          cnt_clr = 1'b1;
          cap_d   = '0;
        end
      end
      COLLECT: begin
        if (done) begin
          // Last slot bypasses the capture register straight into out.
          out_d            = cap_q;
          out_d[N_SLOTS-1] = in_bit;
          out_valid_d      = 1'b1;
          cap_d            = '0;
          if (!start) begin
            state_d = IDLE;
          end
        end else if (start) begin
          abort_d = 1'b1;
          cnt_clr = 1'b1;
          cap_d   = '0;
        end else if (in_valid) begin
          cap_d[sel_w] = in_bit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      abort_q     <= abort_d;
    end
  end

  assign sel       = sel_w;
  assign busy      = (state_q == COLLECT);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_demux1to8_deser.sv
// Bench for demux1to8_deser: directed frames, scoreboard on out_valid.
// Expected words carry the cycle in which out_valid must appear.
module tb_demux1to8_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_bit;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] dout;
  logic       out_valid;
  logic       abort;

  typedef struct {
    logic [7:0] w;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc        = 0;
  int   n_vec      = 0;
  int   n_bad      = 0;
  int   exp_abort  = 0;
  int   seen_abort = 0;

  demux1to8_deser dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .sel       (sel),
    .busy      (busy),
    .out       (dout),
    .out_valid (out_valid),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid || abort) begin
          chk("ov_abort_excl", {31'd0, out_valid & abort}, 0);
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            e = q.pop_front();
            chk("out_word", {24'd0, dout}, {24'd0, e.w});
            chk("out_valid_cycle", cyc, e.cyc);
          end
        end
        if (abort) seen_abort++;
      end
    end
  endtask

  task automatic do_start();
    start    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start_busy", {31'd0, busy}, 1);
    chk("start_sel", {29'd0, sel}, 0);
  endtask

  task automatic frame(input logic [7:0] w, input int st_at,
                       input int st_n, input logic b2b);
    for (int k = 0; k < 8; k++) begin
      chk("sel_step", {29'd0, sel}, k);
      in_valid = 1'b1;
      in_bit   = w[k];
      if (k == 7) begin
        q.push_back('{w, cyc + 1});
        start = b2b;
      end
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      if (k == st_at) begin
        repeat (st_n) begin
          tick();
          chk("sel_stall", {29'd0, sel}, k + 1);
        end
      end
    end
    chk("frame_out", {24'd0, dout}, {24'd0, w});
    chk("frame_busy", {31'd0, busy}, {31'd0, b2b});
    chk("frame_no_abort", {31'd0, abort}, 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    fork
      monitor();
    join_none
    #12;
    chk("rst_sel", {29'd0, sel}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_out", {24'd0, dout}, 0);
    chk("rst_ov", {31'd0, out_valid}, 0);
    chk("rst_abort", {31'd0, abort}, 0);
    rst = 1'b0;
    tick();

    // basic frame
    do_start();
    frame(8'h55, -1, 0, 1'b0);

    // abort after 4 bits, out must keep 8'h55
    do_start();
    repeat (4) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      tick();
    end
    start    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    exp_abort++;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("abort_pulse", {31'd0, abort}, 1);
    chk("abort_sel", {29'd0, sel}, 0);
    chk("abort_out", {24'd0, dout}, 32'h55);
    chk("abort_busy", {31'd0, busy}, 1);
    chk("abort_no_ov", {31'd0, out_valid}, 0);
    frame(8'h0F, -1, 0, 1'b0);

    // stall 3 cycles after slot 2
    do_start();
    frame(8'hA3, 2, 3, 1'b0);

    // back-to-back start on completion, one gap cycle
    do_start();
    frame(8'h3C, -1, 0, 1'b1);
    tick();
    chk("b2b_busy_gap", {31'd0, busy}, 1);
    frame(8'hC3, -1, 0, 1'b0);

    // async reset mid-frame
    do_start();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_bit   = k[0];
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_sel", {29'd0, sel}, 0);
    chk("mid_rst_out", {24'd0, dout}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_ov", {31'd0, out_valid}, 0);
    tick();
    rst = 1'b0;

    // idle noise
    for (int k = 0; k < 6; k++) begin
      in_valid = k[0];
      in_bit   = 1'b1;
      tick();
      chk("idle_sel", {29'd0, sel}, 0);
      chk("idle_busy", {31'd0, busy}, 0);
    end
    in_valid = 1'b0;

    repeat (3) tick();
    chk("pending_words", q.size(), 0);
    chk("abort_count", seen_abort, exp_abort);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
